// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, control
// bundle layout and the canonical NOP loaded on an IF/ID flush.
package pipe_hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        LDSTALL = 2'd2,
        MEMWAIT = 2'd3
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_BOOT   = 7'b0000_111;
    localparam ctrl_t CTRL_RUN    = 7'b1111_000;
    localparam ctrl_t CTRL_BRANCH = 7'b1111_110;
    localparam ctrl_t CTRL_LDUSE  = 7'b0011_010;
    localparam ctrl_t CTRL_MWAIT  = 7'b0000_001;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-status inputs and pipeline-control outputs of the sequencer.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ifid_use_rs1;
    logic             ifid_use_rs2;
    logic             idex_MemRead;
    logic [4:0]       idex_rd;
    logic             ex_branch_taken;
    logic             exmem_MemAccess;
    logic             dmem_ready;
    logic             perf_clr;
    logic             PCWrite;
    logic             ifidWrite;
    logic             idexWrite;
    logic             exmemWrite;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, idex_MemRead,
               idex_rd, ex_branch_taken, exmem_MemAccess, dmem_ready, perf_clr,
        input  PCWrite, ifidWrite, idexWrite, exmemWrite, ifid_flush,
               idex_flush, memwb_bubble, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, idex_MemRead,
               idex_rd, ex_branch_taken, exmem_MemAccess, dmem_ready, perf_clr,
        output PCWrite, ifidWrite, idexWrite, exmemWrite, ifid_flush,
               idex_flush, memwb_bubble, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: boot hold, dmem freeze, branch flush and
// load-use stall prioritised into one FSM with Mealy control outputs.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.slave    bus
);
    localparam int BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

    state_t          state, nxt;
    logic [BW-1:0]   boot_cnt;
    logic [7:0]      wait_cnt;
    logic            timeout_q;
    logic            memwait, loaduse, stall_inc, flush_inc;
    ctrl_t           ctrl;

    always_comb begin
        memwait   = bus.exmem_MemAccess & ~bus.dmem_ready;
        loaduse   = bus.idex_MemRead & (bus.idex_rd != 5'd0) &
                    ((bus.ifid_use_rs1 & (bus.ifid_rs1 == bus.idex_rd)) |
                     (bus.ifid_use_rs2 & (bus.ifid_rs2 == bus.idex_rd)));
        ctrl      = CTRL_RUN;
        nxt       = RUN;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (state == BOOT) begin
            ctrl = CTRL_BOOT;
            nxt  = (boot_cnt == BW'(BOOT_CYCLES - 1)) ? RUN : BOOT;
        end else if (memwait) begin
            // Freeze wins; any branch or hazard is re-seen when it lifts.
            ctrl      = CTRL_MWAIT;
            nxt       = MEMWAIT;
            stall_inc = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ctrl      = CTRL_BRANCH;
            flush_inc = 1'b1;
        end else if (loaduse) begin
            ctrl      = CTRL_LDUSE;
            nxt       = LDSTALL;
            stall_inc = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= nxt;
            if (state == BOOT) begin
                boot_cnt <= boot_cnt + 1'b1;
            end else if (memwait) begin
                if (wait_cnt != 8'(MEM_TIMEOUT))
                    wait_cnt <= wait_cnt + 8'd1;
                if (wait_cnt >= 8'(MEM_TIMEOUT - 1))
                    timeout_q <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign bus.PCWrite      = ctrl.pc_write;
    assign bus.ifidWrite    = ctrl.ifid_write;
    assign bus.idexWrite    = ctrl.idex_write;
    assign bus.exmemWrite   = ctrl.exmem_write;
    assign bus.ifid_flush   = ctrl.ifid_flush;
    assign bus.idex_flush   = ctrl.idex_flush;
    assign bus.memwb_bubble = ctrl.memwb_bubble;
    assign bus.mem_timeout  = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (bus.perf_clr),
        .cnt   (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (bus.perf_clr),
        .cnt   (bus.flush_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a narrow-counter twin shadows the
// main instance so counter saturation is reachable in few cycles.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  sbus ();

    pipe_hazard_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(255), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pipe_hazard_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(255), .CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    assign sbus.ifid_rs1        = bus.ifid_rs1;
    assign sbus.ifid_rs2        = bus.ifid_rs2;
    assign sbus.ifid_use_rs1    = bus.ifid_use_rs1;
    assign sbus.ifid_use_rs2    = bus.ifid_use_rs2;
    assign sbus.idex_MemRead    = bus.idex_MemRead;
    assign sbus.idex_rd         = bus.idex_rd;
    assign sbus.ex_branch_taken = bus.ex_branch_taken;
    assign sbus.exmem_MemAccess = bus.exmem_MemAccess;
    assign sbus.dmem_ready      = bus.dmem_ready;
    assign sbus.perf_clr        = bus.perf_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] ctl;
    assign ctl = {bus.PCWrite, bus.ifidWrite, bus.idexWrite, bus.exmemWrite,
                  bus.ifid_flush, bus.idex_flush, bus.memwb_bubble};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic mr,
                         input logic [4:0] rd, input logic br,
                         input logic ma, input logic rdy);
        bus.ifid_rs1        = rs1;
        bus.ifid_rs2        = rs2;
        bus.ifid_use_rs1    = u1;
        bus.ifid_use_rs2    = u2;
        bus.idex_MemRead    = mr;
        bus.idex_rd         = rd;
        bus.ex_branch_taken = br;
        bus.exmem_MemAccess = ma;
        bus.dmem_ready      = rdy;
        #1;
    endtask

    task automatic idle();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.perf_clr = 1'b0;
        // load-use pattern held through reset and boot: must neither stall nor count
        apply(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        #2;
        chk("rst_ctl", 32'(ctl), 32'(CTRL_BOOT));
        chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
        chk("rst_flush", 32'(bus.flush_cnt), 32'd0);
        chk("rst_tmo", 32'(bus.mem_timeout), 32'd0);
        #19;
        chk("rst_hold_ctl", 32'(ctl), 32'(CTRL_BOOT));
        rst_n = 1'b1;

        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("boot_e%0d", k), 32'(ctl), 32'(CTRL_BOOT));
        end
        idle();
        tick();
        chk("boot_exit_ctl", 32'(ctl), 32'(CTRL_RUN));
        chk("boot_no_cnt", 32'(bus.stall_cnt), 32'd0);

        // lw x5 ; add x6,x5,x1
        apply(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        chk("lu_ctl", 32'(ctl), 32'(CTRL_LDUSE));
        tick();
        idle();
        chk("lu_after_ctl", 32'(ctl), 32'(CTRL_RUN));
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // rs2 match alone also stalls? only when used: addi (no rs2 use, rs1 unused)
        apply(5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        chk("addi_no_stall", 32'(ctl), 32'(CTRL_RUN));
        apply(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("x0_no_stall", 32'(ctl), 32'(CTRL_RUN));
        apply(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        chk("rs2_stall", 32'(ctl), 32'(CTRL_LDUSE));
        idle();
        tick();
        chk("no_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        bus.perf_clr = 1'b1;
        tick();
        bus.perf_clr = 1'b0;
        chk("clr_stall", 32'(bus.stall_cnt), 32'd0);

        // branch with simultaneous load-use
        apply(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("br_lu_ctl", 32'(ctl), 32'(CTRL_BRANCH));
        tick();
        idle();
        chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // dmem wait for 3 cycles with branch and load-use pending
        for (int k = 1; k <= 3; k++) begin
            apply(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
            chk($sformatf("mw_ctl%0d", k), 32'(ctl), 32'(CTRL_MWAIT));
            tick();
        end
        apply(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        chk("mw_exit_br", 32'(ctl), 32'(CTRL_BRANCH));
        tick();
        idle();
        chk("mw_stall_cnt", 32'(bus.stall_cnt), 32'd3);
        chk("mw_flush_cnt", 32'(bus.flush_cnt), 32'd2);
        chk("sat_s_3", 32'(sbus.stall_cnt), 32'd3);

        // back-to-back load-use stalls
        for (int k = 1; k <= 2; k++) begin
            apply(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
            chk($sformatf("b2b_ctl%0d", k), 32'(ctl), 32'(CTRL_LDUSE));
            tick();
        end
        idle();
        chk("b2b_stall_cnt", 32'(bus.stall_cnt), 32'd5);
        chk("sat_s_hold", 32'(sbus.stall_cnt), 32'd3);
        chk("sat_s_flush", 32'(sbus.flush_cnt), 32'd2);

        // clear beats a same-cycle increment
        apply(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        bus.perf_clr = 1'b1;
        tick();
        bus.perf_clr = 1'b0;
        chk("clr_prio_stall", 32'(bus.stall_cnt), 32'd0);
        chk("clr_prio_s", 32'(sbus.stall_cnt), 32'd0);
        chk("clr_prio_flush", 32'(bus.flush_cnt), 32'd0);
        tick();
        idle();
        chk("post_clr_stall", 32'(bus.stall_cnt), 32'd1);

        // memory timeout: wait counter must have restarted from zero
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 254; k++) tick();
        chk("tmo_254", 32'(bus.mem_timeout), 32'd0);
        tick();
        chk("tmo_255", 32'(bus.mem_timeout), 32'd1);
        for (int k = 256; k <= 300; k++) tick();
        chk("tmo_freeze", 32'(ctl), 32'(CTRL_MWAIT));
        chk("tmo_stall_cnt", 32'(bus.stall_cnt), 32'd301);
        idle();
        chk("tmo_exit_ctl", 32'(ctl), 32'(CTRL_RUN));
        tick();
        chk("tmo_sticky", 32'(bus.mem_timeout), 32'd1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_tmo", 32'(bus.mem_timeout), 32'd0);
        chk("rst2_ctl", 32'(ctl), 32'(CTRL_BOOT));
        chk("rst2_stall", 32'(bus.stall_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core. It combines load-use stall detection, taken-branch flush and data-memory wait-state freezing into one prioritised FSM that drives every pipeline-register enable and flush. It holds the pipeline idle for a boot window after reset, flags memory timeouts, and keeps saturating stall and flush counters. It sits beside the forwarding unit and replaces the stand-alone combinational stall logic in ID.

Parameters:
BOOT_CYCLES, 4, cycles after reset release during which the pipeline is held and flushed
MEM_TIMEOUT, 255, consecutive dmem wait cycles before mem_timeout is raised (8-bit counter)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ifid_rs1  in  5  rs1 field of the instruction in IF/ID
ifid_rs2  in  5  rs2 field of the instruction in IF/ID
ifid_use_rs1  in  1  the IF/ID instruction reads rs1
ifid_use_rs2  in  1  the IF/ID instruction reads rs2 (0 for I-type, U-type and JAL)
idex_MemRead  in  1  the ID/EX instruction is a load
idex_rd  in  5  destination register of the ID/EX instruction
ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle
exmem_MemAccess  in  1  the EX/MEM instruction accesses data memory
dmem_ready  in  1  data memory completes the access this cycle
perf_clr  in  1  synchronous clear of the performance counters
PCWrite  out  1  PC register enable
ifidWrite  out  1  IF/ID register enable
idexWrite  out  1  ID/EX register enable
exmemWrite  out  1  EX/MEM register enable
ifid_flush  out  1  load a NOP into IF/ID
idex_flush  out  1  zero the ID/EX control fields (bubble)
memwb_bubble  out  1  zero the MEM/WB control fields
mem_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  count of stall cycles (load-use plus mem wait)
flush_cnt  out  CNT_W  count of branch flush events

Behaviour:
- FSM states: BOOT, RUN, LDSTALL, MEMWAIT. State is registered. Outputs are Mealy: derived from the current state and the current inputs.
- While rst_n = 0: state = BOOT, boot counter = 0, wait counter = 0, mem_timeout = 0, both perf counters = 0. All enables are 0 and all flush/bubble outputs are 1. This holds regardless of clock.
- BOOT: enables 0, flushes 1, for BOOT_CYCLES clock edges after rst_n rises, then go to RUN. A reset asserted mid-operation returns to BOOT asynchronously.
- Conditions are evaluated in priority order, highest first, outside BOOT:
  1. memwait = exmem_MemAccess & ~dmem_ready.
     - PCWrite, ifidWrite, idexWrite and exmemWrite are 0; memwb_bubble = 1; no flushes.
     - Next state is MEMWAIT; wait counter increments.
     - A branch or load-use hazard present in the same cycle is ignored; it is re-evaluated once the freeze ends.
  2. ex_branch_taken.
     - PCWrite = 1 (loads the target); ifid_flush = 1 and idex_flush = 1; all other enables are 1.
     - flush_cnt increments; next state is RUN.
     - A simultaneous load-use hazard is suppressed because its consumer is flushed.
  3. loaduse = idex_MemRead & idex_rd != 0 & ((ifid_use_rs1 & ifid_rs1 == idex_rd) | (ifid_use_rs2 & ifid_rs2 == idex_rd)).
     - PCWrite = 0, ifidWrite = 0, idex_flush = 1; idexWrite and exmemWrite are 1.
     - Next state is LDSTALL; stall_cnt increments.
     - The hazard lasts exactly one cycle because of the bubble.
  4. Otherwise: all enables 1, all flushes 0, next state is RUN.
- MEMWAIT exits to RUN on the first cycle with dmem_ready = 1. That cycle follows normal priority evaluation, and the wait counter clears.
- The wait counter saturates at MEM_TIMEOUT. Reaching MEM_TIMEOUT sets mem_timeout, which stays set until reset; the freeze continues.
- LDSTALL is informational. Next-cycle behaviour uses the same priority rules, so back-to-back hazards produce back-to-back stalls.
- stall_cnt increments on every loaduse or memwait cycle. Both counters saturate at all-ones, never wrap, and do not count during BOOT.
- perf_clr zeroes both counters on the next edge and takes priority over any increment in the same cycle.
- Register x0 never causes a stall.

Decomposition:
- Shared core package holds the state encoding (BOOT = 2'd0, RUN = 2'd1, LDSTALL = 2'd2, MEMWAIT = 2'd3) and the NOP constant used by the IF/ID flush.
- One natural sub-module: sat_counter (parameterised width, inc, clr; saturating). It is instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset, BOOT_CYCLES = 4: after rst_n rises, enables stay 0 and flushes stay 1 for exactly 4 edges, then PCWrite = 1 and idex_flush = 0.
- lw x5 in ID/EX, add x6,x5,x1 in IF/ID: exactly one cycle of PCWrite = 0, ifidWrite = 0, idex_flush = 1; stall_cnt = 1. Repeat with addi x6,x0,1 (use_rs1 = 0) and with idex_rd = 0: no stall.
- ex_branch_taken = 1 together with a load-use match: ifid_flush = 1, idex_flush = 1, PCWrite = 1, no stall; flush_cnt = 1 and stall_cnt = 0.
- exmem_MemAccess = 1 with dmem_ready low for 3 cycles while a branch is pending: 3 frozen cycles with memwb_bubble = 1; the branch flush occurs on the 4th cycle; stall_cnt = 3.
- dmem_ready held low for 300 cycles: mem_timeout rises on cycle 255 and stays high after dmem_ready returns, until rst_n is pulsed low.
- Force counters near saturation (65534) and apply 3 stalls: the counter holds at 65535. perf_clr together with a stall gives 0.
